// File: rtl/datamem_arbiter_if.sv
// Bus bundle between the pipeline MEM stage, the loader/debug port and the data memory.
// The arbiter takes the slave view; the surrounding system takes the master view.
interface datamem_arbiter_if #(
    parameter int ADDR_W = 8
);
    logic              core_req;
    logic              core_we;
    logic [31:0]       core_addr;
    logic [3:0]        core_be;
    logic [31:0]       core_wdata;
    logic              core_stall;
    logic              core_rvalid;
    logic [31:0]       core_rdata;

    logic              ld_req;
    logic              ld_we;
    logic [31:0]       ld_addr;
    logic [3:0]        ld_be;
    logic [31:0]       ld_wdata;
    logic              ld_lock;
    logic              ld_gnt;
    logic              ld_rvalid;
    logic [31:0]       ld_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  core_req, core_we, core_addr, core_be, core_wdata,
        output core_stall, core_rvalid, core_rdata,
        input  ld_req, ld_we, ld_addr, ld_be, ld_wdata, ld_lock,
        output ld_gnt, ld_rvalid, ld_rdata,
        output mem_en, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output core_req, core_we, core_addr, core_be, core_wdata,
        input  core_stall, core_rvalid, core_rdata,
        output ld_req, ld_we, ld_addr, ld_be, ld_wdata, ld_lock,
        input  ld_gnt, ld_rvalid, ld_rdata,
        input  mem_en, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/datamem_arbiter.sv
// Shares a single-port synchronous data memory between the core (fixed priority) and a
// loader port that ages while denied and can lock the memory for uninterrupted bursts.
module datamem_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int STARVE_LIMIT = 4
) (
    input logic              clk,
    input logic              rst_n,
    datamem_arbiter_if.slave bus
);
    typedef enum logic { ARB, LOCK } state_t;
    typedef enum logic [1:0] { OWN_NONE, OWN_CORE, OWN_LD } owner_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state, state_nxt;
    owner_t     rd_owner, rd_owner_nxt;
    logic [3:0] wait_cnt, wait_cnt_nxt;
    logic       core_wins;
    logic       ld_wins;

    // Only the word-select bits of the byte addresses reach the memory; the rest wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.core_addr[31:ADDR_W+2], bus.core_addr[1:0],
                                bus.ld_addr[31:ADDR_W+2], bus.ld_addr[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARB;
            wait_cnt <= 4'd0;
            rd_owner <= OWN_NONE;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            rd_owner <= rd_owner_nxt;
        end
    end

    // Winner selection; while reset is held nobody wins so every handshake stays quiet.
    always_comb begin
        state_nxt = state;
        core_wins = 1'b0;
        ld_wins   = 1'b0;
        case (state)
            ARB: begin
                if (bus.ld_req && (wait_cnt >= LIMIT)) begin
                    ld_wins = 1'b1;
                end else if (bus.core_req) begin
                    core_wins = 1'b1;
                end else if (bus.ld_req) begin
                    ld_wins = 1'b1;
                end
                if (ld_wins && bus.ld_lock) begin
                    state_nxt = LOCK;
                end
            end
            LOCK: begin
                ld_wins = bus.ld_req;
                if (!bus.ld_lock) begin
                    state_nxt = ARB;
                end
            end
            default: state_nxt = ARB;
        endcase
        if (!rst_n) begin
            core_wins = 1'b0;
            ld_wins   = 1'b0;
        end
    end

    always_comb begin
        wait_cnt_nxt = 4'd0;
        if (bus.ld_req && !ld_wins) begin
            wait_cnt_nxt = (wait_cnt == 4'hF) ? wait_cnt : wait_cnt + 4'd1;
        end

        rd_owner_nxt = OWN_NONE;
        if (core_wins && !bus.core_we) begin
            rd_owner_nxt = OWN_CORE;
        end else if (ld_wins && !bus.ld_we) begin
            rd_owner_nxt = OWN_LD;
        end
    end

    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_be    = 4'b0000;
        bus.mem_addr  = '0;
        bus.mem_wdata = 32'd0;
        if (ld_wins) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.ld_we;
            bus.mem_be    = bus.ld_be;
            bus.mem_addr  = bus.ld_addr[ADDR_W+1:2];
            bus.mem_wdata = bus.ld_wdata;
        end else if (core_wins) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.core_we;
            bus.mem_be    = bus.core_be;
            bus.mem_addr  = bus.core_addr[ADDR_W+1:2];
            bus.mem_wdata = bus.core_wdata;
        end
    end

    // Read data is steered to whoever issued the read on the previous edge.
    always_comb begin
        bus.core_stall  = rst_n && bus.core_req && !core_wins;
        bus.ld_gnt      = ld_wins;
        bus.core_rvalid = (rd_owner == OWN_CORE);
        bus.ld_rvalid   = (rd_owner == OWN_LD);
        bus.core_rdata  = (rd_owner == OWN_CORE) ? bus.mem_rdata : 32'd0;
        bus.ld_rdata    = (rd_owner == OWN_LD)   ? bus.mem_rdata : 32'd0;
    end
endmodule
